// File: rtl/mbist_march_ctrl_if.sv
// Memory-under-test port bundle: registered address/data/strobes out, read data returned one cycle after mem_re.
// Latency: none inside the interface; no backpressure, the memory accepts one op every cycle.
interface mbist_march_ctrl_if #(
   parameter int A_WIDTH = 4,
   parameter int D_WIDTH = 8
);
   logic [A_WIDTH-1:0] mem_addr;
   logic [D_WIDTH-1:0] mem_wdata;
   logic               mem_we;
   logic               mem_re;
   logic [D_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_addr,
      output mem_wdata,
      output mem_we,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_wdata,
      input  mem_we,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller with address counter, read comparator and first-fail capture; MBIST_FAIL_CNT_EN adds a saturating fail_cnt.
// Latency: first op one cycle after start is sampled, done 10*2^A_WIDTH+2 cycles after it; no backpressure, one memory op per cycle.
module mbist_march_ctrl #(
   parameter int                 A_WIDTH = 4,
   parameter int                 D_WIDTH = 8,
   parameter logic [D_WIDTH-1:0] DATA_BG = {D_WIDTH{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [A_WIDTH-1:0] fail_addr,
   output logic [2:0]         fail_elem,
   output logic [D_WIDTH-1:0] fail_syndrome,
`ifdef MBIST_FAIL_CNT_EN
   output logic [7:0]         fail_cnt,
`endif
   mbist_march_ctrl_if.master mem
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ELEM,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [A_WIDTH-1:0] ADDR_MAX = {A_WIDTH{1'b1}};
   localparam logic [2:0]         ELEM_LAST = 3'd5;

   state_t             state_q, state_d;
   logic [2:0]         elem_q, elem_d;
   logic               phase_q, phase_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic               launch;

   logic               two_op;
   logic               down;
   logic               next_down;
   logic               is_rd;
   logic               rd_one;
   logic               wr_one;
   logic               last_addr;
   logic               op_last;
   logic               op_vld;
   logic [D_WIDTH-1:0] wr_pat;
   logic [D_WIDTH-1:0] rd_pat;

   logic [D_WIDTH-1:0] exp_q;
   logic [2:0]         tag_elem_q;
   logic [A_WIDTH-1:0] tag_addr_q;
   logic               cmp_vld_q;
   logic [D_WIDTH-1:0] cmp_exp_q;
   logic [2:0]         cmp_elem_q;
   logic [A_WIDTH-1:0] cmp_addr_q;
   logic [D_WIDTH-1:0] syndrome;
   logic               mismatch;

   // Element decode: e1..e4 are (read, write) pairs, e3/e4 walk downwards.
   always_comb begin
      two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
      down      = (elem_q == 3'd3) || (elem_q == 3'd4);
      next_down = (elem_q == 3'd2) || (elem_q == 3'd3);
      is_rd     = two_op ? !phase_q : (elem_q == ELEM_LAST);
      rd_one    = (elem_q == 3'd2) || (elem_q == 3'd4);
      wr_one    = (elem_q == 3'd1) || (elem_q == 3'd3);
      last_addr = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
      op_last   = !two_op || phase_q;
      op_vld    = (state_q == S_ELEM);
      wr_pat    = wr_one ? ~DATA_BG : DATA_BG;
      rd_pat    = rd_one ? ~DATA_BG : DATA_BG;
   end

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      launch  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ELEM;
               elem_d  = 3'd0;
               phase_d = 1'b0;
               addr_d  = '0;
               launch  = 1'b1;
            end
         end
         S_ELEM: begin
            if (!op_last) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (!last_addr) begin
                  addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
               end else if (elem_q == ELEM_LAST) begin
                  state_d = S_DRAIN;
                  addr_d  = '0;
               end else begin
                  // Counter only wraps here, reloading the start address of the next element.
                  elem_d = elem_q + 3'd1;
                  addr_d = next_down ? ADDR_MAX : '0;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         elem_q  <= 3'd0;
         phase_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
      end
   end

   // Memory port and status are registered, so they trail the sequencer state by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem.mem_we    <= 1'b0;
         mem.mem_re    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         exp_q         <= '0;
         tag_elem_q    <= 3'd0;
         tag_addr_q    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         mem.mem_we    <= op_vld && !is_rd;
         mem.mem_re    <= op_vld && is_rd;
         mem.mem_addr  <= op_vld ? addr_q : '0;
         mem.mem_wdata <= (op_vld && !is_rd) ? wr_pat : '0;
         if (op_vld && is_rd) begin
            exp_q      <= rd_pat;
            tag_elem_q <= elem_q;
            tag_addr_q <= addr_q;
         end
         busy <= (state_q == S_ELEM) || (state_q == S_DRAIN);
         done <= (state_q == S_DONE);
      end
   end

   // Second stage lines the expectation up with mem_rdata, which arrives a cycle after mem_re.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_elem_q <= 3'd0;
         cmp_addr_q <= '0;
      end else begin
         cmp_vld_q  <= mem.mem_re;
         cmp_exp_q  <= exp_q;
         cmp_elem_q <= tag_elem_q;
         cmp_addr_q <= tag_addr_q;
      end
   end

   assign syndrome = mem.mem_rdata ^ cmp_exp_q;
   assign mismatch = cmp_vld_q && (syndrome != '0);

   always_ff @(posedge clk) begin
      if (rst || launch) begin
         fail          <= 1'b0;
         fail_addr     <= '0;
         fail_elem     <= 3'd0;
         fail_syndrome <= '0;
      end else if (mismatch && !fail) begin
         fail          <= 1'b1;
         fail_addr     <= cmp_addr_q;
         fail_elem     <= cmp_elem_q;
         fail_syndrome <= syndrome;
      end
   end

`ifdef MBIST_FAIL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || launch) begin
         fail_cnt <= 8'd0;
      end else if (mismatch && (fail_cnt != 8'hFF)) begin
         fail_cnt <= fail_cnt + 8'd1;
      end
   end
`endif

endmodule
